// File: rtl/seg_pkg.sv
// Seven-segment constants and the hex glyph lookup shared by the display path.
package seg_pkg;

  // Active-low glyph encoding, bit order {g,f,e,d,c,b,a}.
  localparam int unsigned SEG_W     = 7;
  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned GLYPH_CNT = 16;

  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [SEG_W-1:0] HEX_GLYPH [GLYPH_CNT] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Map one hex nibble to its active-low glyph.
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIBBLE_W-1:0] nib);
    return HEX_GLYPH[nib];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-glyph decoder with a blanking override.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  input  logic                blank,
  output logic [SEG_W-1:0]    glyph
);

  // Blank forces all segments off; otherwise render the hex digit.
  always_comb begin
    glyph = SEG_BLANK;
    if (!blank) begin
      glyph = hex_to_seg(nibble);
    end
  end

endmodule

// File: rtl/prio_enc_scan.sv
// Registered priority encoder whose code is scanned in hex across a
// multiplexed common-anode seven-segment display.
module prio_enc_scan
  import seg_pkg::*;
#(
  parameter int unsigned N        = 16,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_vec,
  input  logic                 sample,
  output logic                 valid,
  output logic [$clog2(N)-1:0] code,
  output logic                 changed,
  output logic [DIGITS-1:0]    an,
  output logic [SEG_W-1:0]     seg
);

  localparam int unsigned W     = $clog2(N);
  localparam int unsigned CW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned EXT_W = NIBBLE_W * DIGITS;

  localparam logic [CW-1:0] DIV_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

  logic [CW-1:0]       div;
  logic [DW-1:0]       digit;

  logic                valid_n;
  logic [W-1:0]        code_n;
  logic                changed_n;
  logic [CW-1:0]       div_n;
  logic [DW-1:0]       digit_n;
  logic                div_wrap;
  logic [EXT_W-1:0]    code_ext;
  logic [NIBBLE_W-1:0] nibble;
  logic [SEG_W-1:0]    glyph;
  logic [SEG_W-1:0]    seg_n;
  logic [DIGITS-1:0]   an_n;

  // Capture path: highest set bit wins because later loop hits overwrite.
  always_comb begin
    valid_n   = valid;
    code_n    = code;
    changed_n = 1'b0;
    if (sample) begin
      valid_n = |in_vec;
      code_n  = '0;
      for (int i = 0; i < N; i++) begin
        if (in_vec[i]) begin
          code_n = W'(i);
        end
      end
      changed_n = ({valid_n, code_n} != {valid, code});
    end
  end

  // Scan divider and digit index; the index steps on the divider wrap.
  always_comb begin
    div_wrap = (div == DIV_LAST);
    div_n    = div + CW'(1);
    digit_n  = digit;
    if (div_wrap) begin
      div_n = '0;
      if (digit == DIGIT_LAST) begin
        digit_n = '0;
      end else begin
        digit_n = digit + DW'(1);
      end
    end
  end

  // Digit mux works on next-state values so the registered display
  // lines up with the registered code and index on the same edge.
  always_comb begin
    code_ext = EXT_W'(code_n);
    nibble   = NIBBLE_W'(code_ext >> {digit_n, 2'b00});
    an_n     = ~(DIGITS'(1) << digit_n);
  end

  seg_hex_decode u_decode (
    .nibble (nibble),
    .blank  (~valid_n),
    .glyph  (glyph)
  );

  // No capture yet, or an all-zero capture, shows a dash on every digit.
  always_comb begin
    seg_n = SEG_DASH;
    if (valid_n) begin
      seg_n = glyph;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      code    <= '0;
      changed <= 1'b0;
      div     <= '0;
      digit   <= '0;
      an      <= ~DIGITS'(1);
      seg     <= SEG_DASH;
    end else begin
      valid   <= valid_n;
      code    <= code_n;
      changed <= changed_n;
      div     <= div_n;
      digit   <= digit_n;
      an      <= an_n;
      seg     <= seg_n;
    end
  end

endmodule

// File: tb/tb_prio_enc_scan.sv
// Directed self-checking bench for prio_enc_scan with N=16, DIGITS=4, SCAN_DIV=4.
module tb_prio_enc_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_vec;
  logic        sample;
  logic        valid;
  logic [3:0]  code;
  logic        changed;
  logic [3:0]  an;
  logic [6:0]  seg;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Expected captured state, updated by hand at each directed capture.
  logic       ev;
  logic [3:0] ec;

  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] GL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [3:0] AN_SEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  prio_enc_scan #(.N(16), .DIGITS(4), .SCAN_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vec  (in_vec),
    .sample  (sample),
    .valid   (valid),
    .code    (code),
    .changed (changed),
    .an      (an),
    .seg     (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; cyc tracks cycles since the last reset edge.
  task automatic step();
    @(posedge clk);
    if (rst) cyc = 0;
    else     cyc++;
    #1;
  endtask

  // Compare an/seg against the digit implied by cyc and the expected code.
  task automatic check_disp(input string tag);
    int d;
    logic [6:0] es;
    d  = (cyc / 4) % 4;
    es = DASH;
    if (ev) es = (d == 0) ? GL[ec] : GL[0];
    check({tag, "_an"}, 32'(an), 32'(AN_SEQ[d]));
    check({tag, "_seg"}, 32'(seg), 32'(es));
  endtask

  initial begin
    rst = 1'b1; sample = 1'b0; in_vec = '0;
    ev = 1'b0; ec = '0;
    step(); step();
    rst = 1'b0;

    // Reset values.
    check("rst_valid", 32'(valid), 0);
    check("rst_code", 32'(code), 0);
    check("rst_changed", 32'(changed), 0);
    check("rst_an", 32'(an), 32'h0E);
    check("rst_seg", 32'(seg), 32'(DASH));

    // Scan sequence: each digit held 4 cycles, wrap at cycle 16.
    for (int i = 1; i <= 16; i++) begin
      step();
      check("scan_an", 32'(an), 32'(AN_SEQ[(i / 4) % 4]));
      check("idle_seg", 32'(seg), 32'(DASH));
    end
    check("scan_wrap", 32'(an), 32'h0E);

    // Priority: 0x0081 -> 7.
    in_vec = 16'h0081; sample = 1'b1;
    step();
    sample = 1'b0; ev = 1'b1; ec = 4'd7;
    check("cap81_valid", 32'(valid), 1);
    check("cap81_code", 32'(code), 7);
    check("cap81_changed", 32'(changed), 1);
    check_disp("cap81");
    for (int i = 0; i < 16; i++) begin
      step();
      check("cap81_chg_low", 32'(changed), 0);
      check_disp("disp7");
    end

    // Input changes without sample are ignored.
    in_vec = 16'h8000;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_code", 32'(code), 7);
      check("hold_changed", 32'(changed), 0);
    end
    sample = 1'b1;
    step();
    sample = 1'b0; ec = 4'd15;
    check("cap8000_code", 32'(code), 15);
    check("cap8000_changed", 32'(changed), 1);
    for (int i = 0; i < 16; i++) begin
      check_disp("dispF");
      step();
    end

    // Identical capture does not pulse changed.
    sample = 1'b1;
    step();
    sample = 1'b0;
    check("same_changed", 32'(changed), 0);
    check("same_code", 32'(code), 15);

    // Zero capture: invalid, dash everywhere.
    in_vec = 16'h0000; sample = 1'b1;
    step();
    sample = 1'b0; ev = 1'b0; ec = 4'd0;
    check("zero_valid", 32'(valid), 0);
    check("zero_code", 32'(code), 0);
    check("zero_changed", 32'(changed), 1);
    for (int i = 0; i < 16; i++) begin
      check_disp("dispdash");
      step();
    end

    // Back-to-back samples, each compared to the previous cycle.
    sample = 1'b1;
    in_vec = 16'h0001; step();
    check("b2b0_valid", 32'(valid), 1);
    check("b2b0_code", 32'(code), 0);
    check("b2b0_changed", 32'(changed), 1);
    in_vec = 16'h0002; step();
    check("b2b1_code", 32'(code), 1);
    check("b2b1_changed", 32'(changed), 1);
    in_vec = 16'h0003; step();
    check("b2b2_code", 32'(code), 1);
    check("b2b2_changed", 32'(changed), 0);
    in_vec = 16'hFFFF; step();
    check("b2b3_code", 32'(code), 15);
    check("b2b3_changed", 32'(changed), 1);
    sample = 1'b0; ev = 1'b1; ec = 4'd15;

    // Capture on the edge the index wraps back to digit 0.
    for (int i = 0; i < 16 && (cyc % 16) != 15; i++) step();
    check("pre_wrap_an", 32'(an), 32'h07);
    in_vec = 16'h0081; sample = 1'b1;
    step();
    sample = 1'b0; ec = 4'd7;
    check("wrap_an", 32'(an), 32'h0E);
    check("wrap_seg", 32'(seg), 32'b1111000);

    // Reset while digit 2 is active and a sample is pending.
    for (int i = 0; i < 16 && (cyc % 16) != 8; i++) step();
    check("pre_rst_an", 32'(an), 32'h0B);
    in_vec = 16'h0004; sample = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; sample = 1'b0; ev = 1'b0; ec = 4'd0;
    check("mrst_valid", 32'(valid), 0);
    check("mrst_code", 32'(code), 0);
    check("mrst_changed", 32'(changed), 0);
    check("mrst_an", 32'(an), 32'h0E);
    check("mrst_seg", 32'(seg), 32'(DASH));
    for (int i = 0; i < 8; i++) begin
      step();
      check_disp("post_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prio_enc_scan.md
# prio_enc_scan

Parametrised, registered priority encoder with a built-in time-multiplexed seven-segment display driver. Samples an N-bit request vector on a strobe, holds the index of the highest set bit plus a valid flag, and scans that code as hexadecimal across DIGITS common-anode digits. Sits between board switches or request lines and the seven-segment display pins, and supersedes the fixed 8-to-3 combinational encoder and single-digit decoder pair.

## Interface
- N, 16: request vector width; N ≥ 2. Code width W = $clog2(N).
- DIGITS, 4: number of scanned digits; DIGITS ≥ ceil(W/4).
- SCAN_DIV, 1000: clock cycles each digit stays enabled; ≥ 1.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_vec  in  N  request vector; bit i is request i.
- sample  in  1  one-cycle capture strobe.
- valid  out  1  registered; 1 when the captured vector was non-zero.
- code  out  W  registered; index of the highest set bit of the captured vector; 0 when valid = 0.
- changed  out  1  one-cycle pulse when a capture alters {valid, code}.
- an  out  DIGITS  active-low digit enable, exactly one bit low.
- seg  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.

## Operation
- Capture: on a clk edge with sample = 1, valid ← (in_vec ≠ 0) and code ← highest i with in_vec[i] = 1, or 0 if none. Without sample, valid and code hold regardless of in_vec.
- Priority: the highest index wins; for example, in_vec = 0x0081 gives code = 7.
- changed is 1 for the cycle after a capture whose new {valid, code} differs from the old value. Otherwise it is 0, including on a capture of an identical value.
- Scan: the divider counts 0 to SCAN_DIV−1. On the cycle the divider wraps, the digit index increments modulo DIGITS.
- an = ~(1 << digit index).
- Displayed content for digit k:
  - valid = 1: nibble k of the code zero-extended to 4·DIGITS bits, rendered in hex.
  - valid = 0: dash, 7'b0111111.
- Hex glyphs, active-low: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
- an and seg are decoded only from registered state, with no combinational path from in_vec or sample. No latches; every output is assigned on every path.

## Timing
- Reset values: valid = 0, code = 0, changed = 0, divider = 0, digit index = 0, an = ~1 (digit 0 enabled), seg = 7'b0111111.
- Capture latency is 1 cycle: sample at edge t makes valid, code and changed visible after edge t.
- A sample asserted every cycle is legal; each cycle captures independently, and changed is evaluated against the previous cycle's value.
- Each digit is enabled for exactly SCAN_DIV cycles. A full frame is DIGITS·SCAN_DIV cycles, after which the index wraps to 0.
- SCAN_DIV = 1 means the digit index advances every cycle.
- A capture coinciding with a divider wrap: both take effect on the same edge, and the new digit shows the new code.
- rst asserted mid-scan or mid-capture overrides sample and restores every register to its reset value on that edge.

## Structure
- Package seg_pkg holds:
  - SEG_DASH = 7'b0111111 and SEG_BLANK = 7'b1111111.
  - The 16-entry hex glyph constant.
  - A pure function hex_to_seg(logic [3:0]) returning logic [6:0].
- Sub-module seg_hex_decode: combinational, 4-bit nibble plus a blank input mapping to a 7-bit active-low glyph. Instantiated once, fed by the digit mux.
- The priority search is a for loop over N, with the last hit winning.
- Divider width is $clog2(SCAN_DIV) (minimum 1); digit index width is $clog2(DIGITS) (minimum 1).

## Test plan
All scenarios use N = 16, DIGITS = 4, SCAN_DIV = 4.
- Reset, then hold idle: valid = 0, code = 0, changed = 0, an = 4'b1110, seg = 7'b0111111.
- in_vec = 16'h0081 with a 1-cycle sample: next cycle valid = 1, code = 7, changed = 1. While an = 1110, seg = 1111000; on digits 1–3, seg = 1000000.
- Change in_vec to 16'h8000 without sample for 10 cycles: code stays 7 and changed stays 0. Then sample: code = 15, changed = 1, and digit 0 shows 0001110.
- Resample 16'h8000: changed = 0. Sample 16'h0000: valid = 0, code = 0, changed = 1, and all digits show a dash.
- Scan check: an sequences 1110, 1101, 1011, 0111, each held exactly 4 cycles, then 1110 again at cycle 16.
- Assert rst for 1 cycle during a scan, with an = 1011 and sample = 1 on the same edge: all outputs return to their reset values on the next cycle and the capture is discarded.
